// File: rtl/rs485_rx_packet_parser_pkg.sv
// Shared definitions for the RS-485 receive packet parser: FSM states,
// error codes reported on err_code, and the default start-of-packet marker.
package rs485_rx_packet_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } parser_state_t;

    localparam logic [1:0] ERR_BAD_LEN  = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h7E;

    // A LEN byte is legal when it is in 1..max_len.
    function automatic logic len_is_legal(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/rs485_rx_packet_parser_if.sv
// Byte-stream input, committed-FIFO read side and packet status of the parser.
// The slave modport is the parser; the master modport is whoever feeds and reads it.
interface rs485_rx_packet_parser_if #(
    parameter int FIFO_DEPTH = 32
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] fifo_level;
    logic          pkt_ok;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic          busy;

    modport master (
        output rx_byte, rx_valid, rd_en,
        input  rd_data, rd_valid, fifo_level, pkt_ok, pkt_err, err_code, busy
    );

    modport slave (
        input  rx_byte, rx_valid, rd_en,
        output rd_data, rd_valid, fifo_level, pkt_ok, pkt_err, err_code, busy
    );

endinterface

// File: rtl/rs485_rx_packet_parser_commit_fifo.sv
// Payload buffer with commit/rollback. Writes land at wr_ptr but only become
// readable once commit copies wr_ptr into commit_ptr; rollback discards
// everything written since the last commit. Pointers carry one extra wrap bit.
module rs485_rx_packet_parser_commit_fifo #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        commit,
    input  logic        rollback,
    input  logic        pop,
    output logic [7:0]  rd_data,
    output logic [AW:0] level,
    output logic [AW:0] free
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic        pop_ok;

    assign pop_ok  = pop && (commit_ptr != rd_ptr);
    assign level   = commit_ptr - rd_ptr;
    assign free    = DEPTH_W - (wr_ptr - rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping: write side advances or rolls back, read side never passes commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (rollback) begin
                wr_ptr <= commit_ptr;
            end else if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                commit_ptr <= wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rs485_rx_packet_parser.sv
// Frames SYNC, LEN, payload, CHK packets out of the received byte stream.
// Payload goes into a commit/rollback FIFO so readers only ever see bytes of
// packets whose XOR checksum (seeded with LEN) matched. Bad length, lack of
// room, checksum mismatch and inter-byte timeout drop the packet with pkt_err.
module rs485_rx_packet_parser
    import rs485_rx_packet_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         FIFO_DEPTH     = 32,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input logic                    clk,
    input logic                    rst,
    rs485_rx_packet_parser_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    parser_state_t state;
    parser_state_t next_state;
    logic [7:0]    remaining;
    logic [7:0]    chk;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          push;
    logic          commit;
    logic          rollback;
    logic          ok_next;
    logic          err_next;
    logic [1:0]    code_next;
    logic          pkt_ok_q;
    logic          pkt_err_q;
    logic [1:0]    err_code_q;
    logic [AW:0]   level;
    logic [AW:0]   free;

    rs485_rx_packet_parser_commit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rx_byte),
        .commit    (commit),
        .rollback  (rollback),
        .pop       (bus.rd_en),
        .rd_data   (bus.rd_data),
        .level     (level),
        .free      (free)
    );

    // A byte arriving on the terminal cycle still wins over the timeout.
    assign timeout = (state != ST_IDLE) && !bus.rx_valid && (timer == TIMER_LAST);

    assign bus.rd_valid   = (level != '0);
    assign bus.fifo_level = level;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.pkt_ok     = pkt_ok_q;
    assign bus.pkt_err    = pkt_err_q;
    assign bus.err_code   = err_code_q;

    // Parser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus FIFO controls and packet verdict for this cycle.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        code_next  = err_code_q;
        if (timeout) begin
            rollback   = 1'b1;
            err_next   = 1'b1;
            code_next  = ERR_TIMEOUT;
            next_state = ST_IDLE;
        end else if (bus.rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_byte == SYNC_BYTE) begin
                        next_state = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (!len_is_legal(bus.rx_byte, MAX_LEN)) begin
                        err_next   = 1'b1;
                        code_next  = ERR_BAD_LEN;
                        next_state = ST_IDLE;
                    end else if (int'(bus.rx_byte) > int'(free)) begin
                        err_next   = 1'b1;
                        code_next  = ERR_OVERFLOW;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    push = 1'b1;
                    if (remaining == 8'd1) begin
                        next_state = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (bus.rx_byte == chk) begin
                        commit  = 1'b1;
                        ok_next = 1'b1;
                    end else begin
                        rollback  = 1'b1;
                        err_next  = 1'b1;
                        code_next = ERR_CHECKSUM;
                    end
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Byte counter, running checksum, idle timer and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            chk        <= '0;
            timer      <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= '0;
        end else begin
            pkt_ok_q   <= ok_next;
            pkt_err_q  <= err_next;
            err_code_q <= code_next;
            if ((state == ST_IDLE) || bus.rx_valid) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if ((state == ST_LEN) && bus.rx_valid) begin
                remaining <= bus.rx_byte;
                chk       <= bus.rx_byte;
            end else if (push) begin
                remaining <= remaining - 8'd1;
                chk       <= chk ^ bus.rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_rs485_rx_packet_parser.sv
// Self-checking bench for the RS-485 packet parser. Good packets push their
// payload onto a scoreboard queue as they are sent; test_readout pops the queue
// and compares against the committed FIFO output.
module tb_rs485_rx_packet_parser;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs485_rx_packet_parser_if #(.FIFO_DEPTH(32)) bus ();

    rs485_rx_packet_parser #(
        .SYNC_BYTE      (8'h7E),
        .MAX_LEN        (16),
        .FIFO_DEPTH     (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] pkt_q [$];

    // Advance to just after the next rising edge.
    task tick();
        @(posedge clk);
        #1;
    endtask

    task send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task load_payload(input int n, input logic [7:0] seed);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back(seed + 8'(i * 7));
    endtask

    // Sends pkt_q as a correctly checksummed packet and records the expected payload.
    task send_pkt();
        logic [7:0] c;
        c = 8'(pkt_q.size());
        send_byte(8'h7E);
        send_byte(c);
        foreach (pkt_q[i]) begin
            c ^= pkt_q[i];
            exp_q.push_back(pkt_q[i]);
            send_byte(pkt_q[i]);
        end
        send_byte(c);
        pkt_q.delete();
    endtask

    task test_readout(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e)
                $display("[TB] FAIL %s_data: got valid=%b data=%h, expected valid=1 data=%h", name, bus.rd_valid, bus.rd_data, e);
            else pass_cnt++;
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
        end
        total_cnt++;
        if (bus.rd_valid !== 1'b0 || bus.fifo_level !== 6'd0)
            $display("[TB] FAIL %s_empty: got valid=%b level=%0d, expected valid=0 level=0", name, bus.rd_valid, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus.rd_valid, bus.fifo_level, bus.pkt_ok, bus.pkt_err, bus.err_code, bus.busy} !== 12'd0)
            $display("[TB] FAIL reset_outputs: got %h, expected 0", {bus.rd_valid, bus.fifo_level, bus.pkt_ok, bus.pkt_err, bus.err_code, bus.busy});
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task test_good_packet();
        pkt_q.delete();
        pkt_q.push_back(8'h11);
        pkt_q.push_back(8'h22);
        pkt_q.push_back(8'h33);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.pkt_err !== 1'b0 || bus.fifo_level !== 6'd3)
            $display("[TB] FAIL good_commit: got ok=%b err=%b level=%0d, expected ok=1 err=0 level=3", bus.pkt_ok, bus.pkt_err, bus.fifo_level);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.pkt_ok !== 1'b0 || bus.busy !== 1'b0)
            $display("[TB] FAIL good_pulse: got ok=%b busy=%b, expected ok=0 busy=0", bus.pkt_ok, bus.busy);
        else pass_cnt++;
    endtask

    task test_bad_checksum();
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h00);
        total_cnt++;
        if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd2 || bus.pkt_ok !== 1'b0 || bus.fifo_level !== 6'd0)
            $display("[TB] FAIL chk_err: got err=%b code=%0d ok=%b level=%0d, expected err=1 code=2 ok=0 level=0", bus.pkt_err, bus.err_code, bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
        load_payload(5, 8'h40);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.fifo_level !== 6'd5)
            $display("[TB] FAIL chk_recover: got ok=%b level=%0d, expected ok=1 level=5", bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_bad_len();
        send_byte(8'h7E);
        send_byte(8'h00);
        total_cnt++;
        if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd0 || bus.pkt_ok !== 1'b0)
            $display("[TB] FAIL len_zero: got err=%b code=%0d ok=%b, expected err=1 code=0 ok=0", bus.pkt_err, bus.err_code, bus.pkt_ok);
        else pass_cnt++;
        tick();
        send_byte(8'h7E);
        send_byte(8'h11);
        total_cnt++;
        if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd0 || bus.busy !== 1'b0)
            $display("[TB] FAIL len_big: got err=%b code=%0d busy=%b, expected err=1 code=0 busy=0", bus.pkt_err, bus.err_code, bus.busy);
        else pass_cnt++;
        tick();
    endtask

    task test_overflow();
        load_payload(16, 8'h01);
        send_pkt();
        load_payload(4, 8'h90);
        send_pkt();
        send_byte(8'h7E);
        send_byte(8'h10);
        total_cnt++;
        if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd1 || bus.busy !== 1'b0 || bus.fifo_level !== 6'd20)
            $display("[TB] FAIL overflow: got err=%b code=%0d busy=%b level=%0d, expected err=1 code=1 busy=0 level=20", bus.pkt_err, bus.err_code, bus.busy, bus.fifo_level);
        else pass_cnt++;
        tick();
    endtask

    task test_full_boundary();
        load_payload(16, 8'h23);
        send_pkt();
        load_payload(4, 8'hB0);
        send_pkt();
        load_payload(12, 8'h61);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.fifo_level !== 6'd32)
            $display("[TB] FAIL exact_fit: got ok=%b level=%0d, expected ok=1 level=32", bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_timeout();
        int seen_err;
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        seen_err = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus.pkt_err === 1'b1) seen_err++;
        end
        total_cnt++;
        if (seen_err !== 0 || bus.busy !== 1'b1)
            $display("[TB] FAIL timeout_early: got errs=%0d busy=%b, expected errs=0 busy=1", seen_err, bus.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd3 || bus.busy !== 1'b0 || bus.fifo_level !== 6'd0)
            $display("[TB] FAIL timeout_fire: got err=%b code=%0d busy=%b level=%0d, expected err=1 code=3 busy=0 level=0", bus.pkt_err, bus.err_code, bus.busy, bus.fifo_level);
        else pass_cnt++;
        load_payload(3, 8'hC5);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.fifo_level !== 6'd3)
            $display("[TB] FAIL timeout_rollback: got ok=%b level=%0d, expected ok=1 level=3", bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_timeout_edge();
        int seen_err;
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        seen_err = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus.pkt_err === 1'b1) seen_err++;
        end
        send_byte(8'h03);
        total_cnt++;
        if (seen_err !== 0 || bus.pkt_err !== 1'b0 || bus.busy !== 1'b1)
            $display("[TB] FAIL timeout_edge: got errs=%0d err=%b busy=%b, expected errs=0 err=0 busy=1", seen_err, bus.pkt_err, bus.busy);
        else pass_cnt++;
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.fifo_level !== 6'd4)
            $display("[TB] FAIL timeout_edge_commit: got ok=%b level=%0d, expected ok=1 level=4", bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_back_to_back();
        load_payload(2, 8'h0A);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1)
            $display("[TB] FAIL b2b_first: got ok=%b, expected ok=1", bus.pkt_ok);
        else pass_cnt++;
        load_payload(6, 8'h7E);
        send_pkt();
        total_cnt++;
        if (bus.pkt_ok !== 1'b1 || bus.fifo_level !== 6'd8)
            $display("[TB] FAIL b2b_second: got ok=%b level=%0d, expected ok=1 level=8", bus.pkt_ok, bus.fifo_level);
        else pass_cnt++;
    endtask

    task test_pop_during_rx_and_reset();
        logic [7:0] seq [6];
        logic [7:0] e;
        int         pops;
        int         seen_err;
        load_payload(3, 8'hE1);
        send_pkt();
        seq[0] = 8'h7E; seq[1] = 8'h08; seq[2] = 8'hD0;
        seq[3] = 8'hD1; seq[4] = 8'hD2; seq[5] = 8'hD3;
        pops = 0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                total_cnt++;
                if (bus.rd_data !== e)
                    $display("[TB] FAIL pop_rx_data: got %h, expected %h", bus.rd_data, e);
                else pass_cnt++;
                pops++;
            end
            send_byte(seq[i]);
        end
        total_cnt++;
        if (pops !== 3 || bus.rd_valid !== 1'b0 || bus.fifo_level !== 6'd0 || bus.busy !== 1'b1)
            $display("[TB] FAIL pop_boundary: got pops=%0d valid=%b level=%0d busy=%b, expected pops=3 valid=0 level=0 busy=1", pops, bus.rd_valid, bus.fifo_level, bus.busy);
        else pass_cnt++;
        bus.rd_en = 1'b0;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({bus.rd_valid, bus.fifo_level, bus.pkt_ok, bus.pkt_err, bus.err_code, bus.busy} !== 12'd0)
            $display("[TB] FAIL midpkt_reset: got %h, expected 0", {bus.rd_valid, bus.fifo_level, bus.pkt_ok, bus.pkt_err, bus.err_code, bus.busy});
        else pass_cnt++;
        rst = 1'b0;
        seen_err = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus.pkt_err === 1'b1 || bus.busy === 1'b1) seen_err++;
        end
        total_cnt++;
        if (seen_err !== 0 || bus.rd_valid !== 1'b0)
            $display("[TB] FAIL post_reset_quiet: got events=%0d valid=%b, expected events=0 valid=0", seen_err, bus.rd_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        test_reset();
        test_good_packet();
        test_readout("good");
        test_bad_checksum();
        test_readout("chk");
        test_bad_len();
        test_overflow();
        test_readout("overflow");
        test_full_boundary();
        test_readout("full");
        test_timeout();
        test_readout("timeout");
        test_timeout_edge();
        test_readout("timeout_edge");
        test_back_to_back();
        test_readout("b2b");
        test_pop_during_rx_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected completion before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
